// File: rtl/seq_gen_pkg.sv
// Shared definitions for the sequence generator.
// Mode encodings and FSM state type used by seq_gen and seq_step.
package seq_gen_pkg;

    localparam logic [1:0] MODE_FIB   = 2'b00;
    localparam logic [1:0] MODE_LUCAS = 2'b01;
    localparam logic [1:0] MODE_ARITH = 2'b10;
    localparam logic [1:0] MODE_GEN   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_step.sv
// Combinational next-term adder for seq_gen.
// Ports: mode selects operands; cur/nxt are the current term pair,
// inc is the latched arithmetic step; sum is WIDTH+1 bits (MSB = carry).
module seq_step
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] nxt,
    input  logic [WIDTH-1:0] inc,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH-1:0] op_a;

    // Arithmetic progression adds the fixed step; every other
    // mode is a two-term recurrence.
    always_comb begin
        op_a = cur;
        if (mode == MODE_ARITH) begin
            op_a = inc;
        end
        sum = {1'b0, op_a} + {1'b0, nxt};
    end

endmodule

// File: rtl/seq_gen.sv
// Integer sequence generator (Fibonacci, Lucas, arithmetic, generalised).
// Ports: clk, reset (async active-low), start/stop control, mode, seed0/1,
// out_ready in; out_valid, value, index, overflow, busy out.
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] value,
    output logic [IDX_W-1:0] index,
    output logic             overflow,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] nxt_q, nxt_d;
    logic [WIDTH-1:0] inc_q, inc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             nxt_ovf_q, nxt_ovf_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   step_sum;
    logic [WIDTH:0]   seed_sum;

    seq_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode (mode_q),
        .cur  (cur_q),
        .nxt  (nxt_q),
        .inc  (inc_q),
        .sum  (step_sum)
    );

    // Second arithmetic term may itself be unrepresentable.
    assign seed_sum = {1'b0, seed0} + {1'b0, seed1};

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cur_d     = cur_q;
        nxt_d     = nxt_q;
        inc_d     = inc_q;
        idx_d     = idx_q;
        nxt_ovf_d = nxt_ovf_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    mode_d    = mode;
                    inc_d     = seed1;
                    idx_d     = '0;
                    ovf_d     = 1'b0;
                    nxt_ovf_d = 1'b0;
                    unique case (mode)
                        MODE_FIB: begin
                            cur_d = '0;
                            nxt_d = WIDTH'(1);
                        end
                        MODE_LUCAS: begin
                            cur_d = WIDTH'(2);
                            nxt_d = WIDTH'(1);
                        end
                        MODE_ARITH: begin
                            cur_d               = seed0;
                            {nxt_ovf_d, nxt_d}  = seed_sum;
                        end
                        default: begin
                            cur_d = seed0;
                            nxt_d = seed1;
                        end
                    endcase
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    // Terminal handshakes leave cur/index on the last term.
                    if (nxt_ovf_q) begin
                        state_d = DONE;
                        ovf_d   = 1'b1;
                    end else if (&idx_q) begin
                        state_d = DONE;
                    end else begin
                        cur_d              = nxt_q;
                        {nxt_ovf_d, nxt_d} = step_sum;
                        idx_d              = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            cur_q     <= '0;
            nxt_q     <= '0;
            inc_q     <= '0;
            idx_q     <= '0;
            nxt_ovf_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cur_q     <= cur_d;
            nxt_q     <= nxt_d;
            inc_q     <= inc_d;
            idx_q     <= idx_d;
            nxt_ovf_q <= nxt_ovf_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign value     = cur_q;
    assign index     = idx_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter WIDTH, default 64, bit width of every sequence term.
REQ-002 Parameter IDX_W, default 16, bit width of the term index counter.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  in  1  one-cycle pulse that begins a sequence with the current mode/seed0/seed1.
REQ-006 stop  in  1  abort of a running sequence.
REQ-007 mode  in  2  00 Fibonacci (0,1), 01 Lucas (2,1), 10 arithmetic (seed0, +seed1), 11 generalised Fibonacci (seed0, seed1).
REQ-008 seed0, seed1  in  WIDTH  seeds, sampled only on an accepted start.
REQ-009 out_ready  in  1  consumer accepts the current term.
REQ-010 out_valid  out  1  value/index hold a valid term.
REQ-011 value  out  WIDTH  current term.
REQ-012 index  out  IDX_W  ordinal of the current term; the first term is 0.
REQ-013 overflow  out  1  sticky flag: the next term exceeded WIDTH bits.
REQ-014 busy  out  1  high in RUN.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, start SHALL, on the next edge:
  - load the term registers cur and nxt from mode and the seeds;
  - clear index and overflow;
  - enter RUN with out_valid=1 and value=cur.
REQ-017 Term seeding SHALL be: mode 10 gives cur=seed0, nxt=seed0+seed1; mode 11 gives cur=seed0, nxt=seed1.
REQ-018 The next-term rule SHALL be nxt_new=cur+nxt for modes 00/01/11, and nxt_new=nxt+seed1 (latched) for mode 10.
REQ-019 Each next-term sum SHALL be computed WIDTH+1 bits wide; the carry SHALL be stored as nxt_ovf.
REQ-020 A handshake (out_valid & out_ready) with nxt_ovf=0 and index not all-ones SHALL:
  - set cur<=nxt and nxt<=nxt_new;
  - increment index;
  - keep out_valid=1 with no bubble.
REQ-021 A handshake with nxt_ovf=1 SHALL enter DONE with out_valid=0 and overflow=1.
REQ-022 A handshake with index all-ones SHALL enter DONE with out_valid=0 and overflow unchanged (0).
REQ-023 While out_valid=1 and out_ready=0, value and index SHALL be held stable.
REQ-024 stop in RUN SHALL enter IDLE next edge with out_valid=0; stop takes priority over a simultaneous handshake, and that term counts as consumed.
REQ-025 start SHALL be ignored in RUN; stop SHALL be ignored in IDLE and DONE.
REQ-026 In DONE, value and index SHALL hold the last accepted term, and overflow SHALL hold until the next start.
REQ-027 The seed-to-value latency SHALL be exactly 1 cycle after the start edge.

Reset
REQ-028 While reset=0 the block SHALL asynchronously force:
  - state=IDLE;
  - out_valid=0, busy=0, overflow=0;
  - value=0, index=0;
  - all internal registers 0.
REQ-029 Reset asserted mid-RUN SHALL discard the sequence; no term is presented after release until a new start.
REQ-030 Reset release SHALL be synchronous-safe; the first start SHALL be honoured on the first edge after release.

Structure
REQ-031 Package seq_gen_pkg SHALL hold:
  - the mode encodings (MODE_FIB, MODE_LUCAS, MODE_ARITH, MODE_GEN);
  - the state enum (IDLE, RUN, DONE).
REQ-032 One sub-module, seq_step, SHALL hold the combinational next-term adder (mode-selected operands, WIDTH+1 result with carry); the FSM and registers SHALL stay in seq_gen.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
  - Fibonacci, WIDTH=8, out_ready=1: emits 0,1,1,2,...,233 with index 0..13, then out_valid=0 and overflow=1.
  - Lucas, WIDTH=8: emits 2,1,3,4,7,11,18,29,47,76,123,199 (index 0..11), then overflow=1.
  - Arithmetic, WIDTH=8, seed0=250, seed1=3: emits 250, 253, then overflow=1 (256 not representable).
  - Backpressure, Fibonacci, WIDTH=64, out_ready toggling 1010...: every term is held while ready=0 and none is skipped or duplicated; 94 terms (F(93)=12200160415121876738 last), then overflow.
  - Stop with out_ready=1 at index 5: IDLE next cycle, out_valid=0; a start with mode 11 (seed0=5, seed1=5) then yields 5,5,10,15 with index restarting at 0.
  - Reset asserted asynchronously mid-RUN between clock edges: outputs are 0 immediately; after release, no output until start.
